// File: rtl/servant_ext_irq_gen.sv
// Interrupt stimulus for the servant harness: raises ext_irq after a programmable delay,
// holds it until mret, re-arms periodically and records entry/service latency.
module servant_ext_irq_gen #(
    parameter int unsigned INTERRUPT_TIME = 3000,
    parameter int unsigned PERIOD         = 0,
    parameter int unsigned MAX_IRQS       = 0,
    parameter logic [31:0] HANDLER_ADR    = 32'h0,
    parameter int unsigned TIMEOUT        = 100000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             wb_clk,
    input  logic             wb_rst,
    input  logic             i_en,
    input  logic [31:0]      pc_adr,
    input  logic             pc_vld,
    input  logic             mret,
    output logic             ext_irq,
    output logic [15:0]      o_irq_cnt,
    output logic [CNT_W-1:0] o_entry_lat,
    output logic [CNT_W-1:0] o_lat,
    output logic             o_lat_vld,
    output logic             o_timeout,
    output logic             o_spurious,
    output logic             o_done
);

    // The release cycle after reset is itself a counted cycle, so the first delay loads one less.
    localparam logic [CNT_W-1:0] FIRST_LOAD  = CNT_W'(INTERRUPT_TIME - 1);
    localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] LAT_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [31:0]      MAX_V       = 32'(MAX_IRQS);
    localparam logic             ONE_SHOT    = (PERIOD == 0);
    localparam logic             LIMITED     = (MAX_IRQS != 0);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_ACTIVE,
        ST_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lat;
    logic             entry_seen;
    logic             entry_hit;
    logic             last_irq;

    assign entry_hit = pc_vld && (pc_adr == HANDLER_ADR) && !entry_seen;
    assign last_irq  = ONE_SHOT || (LIMITED && ({16'd0, o_irq_cnt} == MAX_V));

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state       <= ST_WAIT;
            cnt         <= FIRST_LOAD;
            lat         <= '0;
            entry_seen  <= 1'b0;
            ext_irq     <= 1'b0;
            o_irq_cnt   <= '0;
            o_entry_lat <= '0;
            o_lat       <= '0;
            o_lat_vld   <= 1'b0;
            o_timeout   <= 1'b0;
            o_spurious  <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_lat_vld <= 1'b0;
            if (mret && (state != ST_ACTIVE)) begin
                o_spurious <= 1'b1;
            end

            case (state)
                ST_WAIT: begin
                    if (i_en) begin
                        if (cnt <= CNT_W'(1)) begin
                            state      <= ST_ACTIVE;
                            ext_irq    <= 1'b1;
                            cnt        <= '0;
                            lat        <= '0;
                            entry_seen <= 1'b0;
                            if (o_irq_cnt != 16'hFFFF) begin
                                o_irq_cnt <= o_irq_cnt + 16'd1;
                            end
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end

                ST_ACTIVE: begin
                    if (entry_hit) begin
                        o_entry_lat <= lat;
                        entry_seen  <= 1'b1;
                    end
                    // mret takes priority over a timeout landing on the same cycle.
                    if (mret) begin
                        o_lat     <= lat;
                        o_lat_vld <= 1'b1;
                        ext_irq   <= 1'b0;
                        if (last_irq) begin
                            state  <= ST_DONE;
                            o_done <= 1'b1;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= PERIOD_LOAD;
                        end
                    end else if (lat == LAT_LAST) begin
                        o_timeout <= 1'b1;
                        ext_irq   <= 1'b0;
                        state     <= ST_DONE;
                        o_done    <= 1'b1;
                    end else begin
                        lat <= lat + CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    ext_irq <= 1'b0;
                    o_done  <= 1'b1;
                end

                default: begin
                    state <= ST_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_servant_ext_irq_gen.sv
// Bench for servant_ext_irq_gen: a one-shot instance (A) and a periodic, limited instance (B)
// share clock/reset/enable/PC stimulus and are checked each cycle against a timestamp model.
module tb_servant_ext_irq_gen;

    localparam logic [31:0] HADR = 32'h0000_0100;

    logic        wb_clk;
    logic        wb_rst;
    logic        i_en;
    logic [31:0] pc_adr;
    logic        pc_vld;
    logic        mret_a;
    logic        mret_b;

    logic        irq_a, vld_a, to_a, sp_a, done_a;
    logic [15:0] cnt_a;
    logic [31:0] entry_a, lat_a;
    logic        irq_b, vld_b, to_b, sp_b, done_b;
    logic [15:0] cnt_b;
    logic [15:0] entry_b, lat_b;

    int checks   = 0;
    int failures = 0;

    servant_ext_irq_gen #(
        .INTERRUPT_TIME(10), .PERIOD(0), .MAX_IRQS(0),
        .HANDLER_ADR(HADR), .TIMEOUT(20), .CNT_W(32)
    ) u_a (
        .wb_clk(wb_clk), .wb_rst(wb_rst), .i_en(i_en), .pc_adr(pc_adr), .pc_vld(pc_vld),
        .mret(mret_a), .ext_irq(irq_a), .o_irq_cnt(cnt_a), .o_entry_lat(entry_a),
        .o_lat(lat_a), .o_lat_vld(vld_a), .o_timeout(to_a), .o_spurious(sp_a), .o_done(done_a)
    );

    servant_ext_irq_gen #(
        .INTERRUPT_TIME(10), .PERIOD(5), .MAX_IRQS(3),
        .HANDLER_ADR(HADR), .TIMEOUT(20), .CNT_W(16)
    ) u_b (
        .wb_clk(wb_clk), .wb_rst(wb_rst), .i_en(i_en), .pc_adr(pc_adr), .pc_vld(pc_vld),
        .mret(mret_b), .ext_irq(irq_b), .o_irq_cnt(cnt_b), .o_entry_lat(entry_b),
        .o_lat(lat_b), .o_lat_vld(vld_b), .o_timeout(to_b), .o_spurious(sp_b), .o_done(done_b)
    );

    initial begin
        wb_clk = 1'b0;
        forever #5 wb_clk = ~wb_clk;
    end

    function automatic int period_of(input int i);
        return (i == 0) ? 0 : 5;
    endfunction

    function automatic int max_of(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    localparam int IT_CYC  = 10;
    localparam int TO_CYC  = 20;

    task automatic chk(input string name, input int inst, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0h exp=%0h", name, inst, mcyc, got, exp);
        end
    endtask

    // Model state: timestamps instead of counters; mcyc is the current cycle number.
    int          mcyc = 0;
    bit          started = 0;
    bit          m_hi[2], m_done[2], m_vld[2], m_to[2], m_sp[2], m_seen[2];
    int          m_rise[2], m_need[2], m_irqs[2];
    logic [31:0] m_entry[2], m_lat[2];

    task automatic model_reset(input int i);
        m_hi[i] = 0; m_done[i] = 0; m_vld[i] = 0; m_to[i] = 0; m_sp[i] = 0; m_seen[i] = 0;
        m_rise[i] = 0; m_irqs[i] = 0; m_entry[i] = 0; m_lat[i] = 0;
        // With enable held, first rise is in cycle IT_CYC: IT_CYC-1 enabled cycles are owed.
        m_need[i] = IT_CYC - 1;
    endtask

    task automatic model_step(input int i, input logic mr);
        int el;
        m_vld[i] = 0;
        if (mr && !m_hi[i]) m_sp[i] = 1;
        if (m_hi[i]) begin
            el = mcyc - m_rise[i];
            if (pc_vld && pc_adr == HADR && !m_seen[i]) begin
                m_entry[i] = 32'(el);
                m_seen[i]  = 1;
            end
            if (mr) begin
                m_lat[i] = 32'(el);
                m_vld[i] = 1;
                m_hi[i]  = 0;
                if (period_of(i) == 0 || (max_of(i) != 0 && m_irqs[i] == max_of(i)))
                    m_done[i] = 1;
                else
                    m_need[i] = period_of(i);
            end else if (el == TO_CYC - 1) begin
                m_to[i]   = 1;
                m_hi[i]   = 0;
                m_done[i] = 1;
            end
        end else if (!m_done[i] && i_en) begin
            m_need[i]--;
            if (m_need[i] <= 0) begin
                m_hi[i]   = 1;
                m_rise[i] = mcyc + 1;
                m_seen[i] = 0;
                if (m_irqs[i] < 65535) m_irqs[i]++;
            end
        end
    endtask

    task automatic cmp(input int i, input logic irq, input logic [15:0] cnt,
                       input logic [31:0] ent, input logic [31:0] lt, input logic vld,
                       input logic to, input logic sp, input logic dn);
        chk("ext_irq",     i, 32'(irq), 32'(m_hi[i]));
        chk("o_irq_cnt",   i, 32'(cnt), 32'(m_irqs[i]));
        chk("o_entry_lat", i, ent,      m_entry[i]);
        chk("o_lat",       i, lt,       m_lat[i]);
        chk("o_lat_vld",   i, 32'(vld), 32'(m_vld[i]));
        chk("o_timeout",   i, 32'(to),  32'(m_to[i]));
        chk("o_spurious",  i, 32'(sp),  32'(m_sp[i]));
        chk("o_done",      i, 32'(dn),  32'(m_done[i]));
    endtask

    // Compare this cycle's outputs, then advance the model with this cycle's inputs.
    always @(negedge wb_clk) begin
        if (started) begin
            cmp(0, irq_a, cnt_a, entry_a, lat_a, vld_a, to_a, sp_a, done_a);
            cmp(1, irq_b, cnt_b, 32'(entry_b), 32'(lat_b), vld_b, to_b, sp_b, done_b);
        end
        if (wb_rst) begin
            model_reset(0);
            model_reset(1);
            mcyc    = 1;
            started = 1;
        end else if (started) begin
            model_step(0, mret_a);
            model_step(1, mret_b);
            mcyc++;
        end
    end

    task automatic idle_inputs();
        i_en = 1'b1; pc_vld = 1'b0; pc_adr = 32'h0; mret_a = 1'b0; mret_b = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic do_reset();
        wb_rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge wb_clk);
        #1;
        wb_rst = 1'b0;
    endtask

    initial begin
        wb_rst = 1'b1;
        idle_inputs();
        do_reset();

        // One-shot service on A, three periodic pulses on B, entry-latency capture.
        for (int c = 1; c <= 40; c++) begin
            idle_inputs();
            case (c)
                12:     begin pc_vld = 1'b1; pc_adr = HADR + 32'd4; end
                13:     pc_adr = HADR;
                14, 15: mret_b = 1'b1;
                17, 19: begin pc_vld = 1'b1; pc_adr = HADR; end
                22, 27: i_en = 1'b0;
                24, 35: mret_b = 1'b1;
                25:     mret_a = 1'b1;
                default: ;
            endcase
            case (c)
                9:  chk("t1_low_before_rise", 0, 32'(irq_a), 32'd0);
                10: begin
                    chk("t1_rise", 0, 32'(irq_a), 32'd1);
                    chk("t1_cnt", 0, 32'(cnt_a), 32'd1);
                    chk("t3_rise1", 1, 32'(irq_b), 32'd1);
                end
                15: begin
                    chk("t3_fall1", 1, 32'(irq_b), 32'd0);
                    chk("t3_lat1", 1, 32'(lat_b), 32'd4);
                end
                16: chk("spurious_after_fall", 1, 32'(sp_b), 32'd1);
                18: chk("t4_entry", 0, entry_a, 32'd7);
                19: chk("t3_gap", 1, 32'(irq_b), 32'd0);
                20: begin
                    chk("t4_entry_hold", 0, entry_a, 32'd7);
                    chk("t3_rise2", 1, 32'(irq_b), 32'd1);
                    chk("t3_cnt2", 1, 32'(cnt_b), 32'd2);
                    chk("entry_ignored_wait", 1, 32'(entry_b), 32'd0);
                end
                26: begin
                    chk("t2_fall", 0, 32'(irq_a), 32'd0);
                    chk("t2_lat", 0, lat_a, 32'd15);
                    chk("t2_lat_vld", 0, 32'(vld_a), 32'd1);
                    chk("t2_done", 0, 32'(done_a), 32'd1);
                end
                27: chk("t2_vld_pulse", 0, 32'(vld_a), 32'd0);
                30: chk("en_low_delays", 1, 32'(irq_b), 32'd0);
                31: begin
                    chk("t3_rise3", 1, 32'(irq_b), 32'd1);
                    chk("t3_cnt3", 1, 32'(cnt_b), 32'd3);
                end
                36: begin
                    chk("t3_done", 1, 32'(done_b), 32'd1);
                    chk("t3_final_low", 1, 32'(irq_b), 32'd0);
                end
                40: begin
                    chk("one_shot_cnt", 0, 32'(cnt_a), 32'd1);
                    chk("no_spurious", 0, 32'(sp_a), 32'd0);
                end
                default: ;
            endcase
            next_cycle();
        end

        // Timeout on A; mret exactly at the timeout cycle on B, then a later B timeout.
        do_reset();
        for (int c = 1; c <= 58; c++) begin
            idle_inputs();
            if (c == 29) mret_b = 1'b1;
            case (c)
                1: begin
                    chk("rst_irq", 0, 32'(irq_a), 32'd0);
                    chk("rst_cnt", 0, 32'(cnt_a), 32'd0);
                    chk("rst_lat", 0, lat_a, 32'd0);
                    chk("rst_entry", 0, entry_a, 32'd0);
                    chk("rst_done", 0, 32'(done_a), 32'd0);
                    chk("rst_spurious", 1, 32'(sp_b), 32'd0);
                end
                29: chk("t5_last_high", 0, 32'(irq_a), 32'd1);
                30: begin
                    chk("t5_fall", 0, 32'(irq_a), 32'd0);
                    chk("t5_timeout", 0, 32'(to_a), 32'd1);
                    chk("t5_done", 0, 32'(done_a), 32'd1);
                    chk("t5_lat_kept", 0, lat_a, 32'd0);
                    chk("mret_wins_to", 1, 32'(to_b), 32'd0);
                    chk("mret_wins_lat", 1, 32'(lat_b), 32'd19);
                    chk("mret_wins_done", 1, 32'(done_b), 32'd0);
                end
                35: chk("rearm_cnt", 1, 32'(cnt_b), 32'd2);
                54: chk("b_last_high", 1, 32'(irq_b), 32'd1);
                55: begin
                    chk("b_timeout", 1, 32'(to_b), 32'd1);
                    chk("b_timeout_fall", 1, 32'(irq_b), 32'd0);
                end
                default: ;
            endcase
            next_cycle();
        end

        // Spurious mret in WAIT, then a reset pulse in the middle of ACTIVE.
        do_reset();
        for (int c = 1; c <= 14; c++) begin
            idle_inputs();
            case (c)
                3:  mret_a = 1'b1;
                12: begin pc_vld = 1'b1; pc_adr = HADR; end
                14: wb_rst = 1'b1;
                default: ;
            endcase
            case (c)
                3:  chk("t6_pre_spurious", 0, 32'(sp_a), 32'd0);
                4:  chk("t6_spurious", 0, 32'(sp_a), 32'd1);
                13: chk("t6_entry", 0, entry_a, 32'd2);
                14: chk("t6_active", 0, 32'(irq_a), 32'd1);
                default: ;
            endcase
            next_cycle();
        end
        wb_rst = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            idle_inputs();
            case (c)
                1: begin
                    chk("t6_rst_irq", 0, 32'(irq_a), 32'd0);
                    chk("t6_rst_sp", 0, 32'(sp_a), 32'd0);
                    chk("t6_rst_cnt", 0, 32'(cnt_a), 32'd0);
                    chk("t6_rst_entry", 0, entry_a, 32'd0);
                end
                9:  chk("t6_relow", 0, 32'(irq_a), 32'd0);
                10: begin
                    chk("t6_rerise", 0, 32'(irq_a), 32'd1);
                    chk("t6_recnt", 0, 32'(cnt_a), 32'd1);
                end
                default: ;
            endcase
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
